// File: rtl/parameters_pkg.sv
// parameters_pkg: shared async-FIFO pointer geometry and Gray/binary helpers.
package parameters_pkg;
  localparam int ADDR_WIDTH = 3;
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
    logic [PTR_WIDTH-1:0] b;
    for (int i = 0; i < PTR_WIDTH; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/fifo_gray_to_bin.sv
// fifo_gray_to_bin: combinational Gray-to-binary converter, each bit the XOR of all Gray bits at or above it.
module fifo_gray_to_bin
  import parameters_pkg::*;
(
  input  logic [PTR_WIDTH-1:0] gray_i,
  output logic [PTR_WIDTH-1:0] bin_o
);
  for (genvar i = 0; i < PTR_WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[PTR_WIDTH-1:i];
  end
endmodule

// File: rtl/fifo_wr_ptr_full.sv
// fifo_wr_ptr_full: async-FIFO write-side pointer, full flag and sticky overflow.
// Define FIFO_ALMOST_FULL_EN to build the registered almost-full flag; otherwise wafull is held at 0.
module fifo_wr_ptr_full
  import parameters_pkg::*;
#(
  parameter int AFULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [PTR_WIDTH-1:0]  wq2_rptr,
  output logic [PTR_WIDTH-1:0]  wptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wen,
  output logic                  wfull,
  output logic                  wovf,
  output logic                  wafull
);
  logic [PTR_WIDTH-1:0] wbin_q, wbin_d, wptr_q, wptr_d;
  logic                 wfull_q, wfull_d, wovf_q, wafull_q, wafull_d;

  assign wen    = winc & ~wfull_q;
  assign wbin_d = wbin_q + PTR_WIDTH'(wen);
  assign wptr_d = bin2gray(wbin_d);
  // Full when write leads read by exactly DEPTH: Gray form differs in the top two bits only.
  assign wfull_d = wptr_d == {~wq2_rptr[PTR_WIDTH-1:PTR_WIDTH-2], wq2_rptr[PTR_WIDTH-3:0]};

`ifdef FIFO_ALMOST_FULL_EN
  logic [PTR_WIDTH-1:0] rbin, occ;
  fifo_gray_to_bin u_g2b (
    .gray_i (wq2_rptr),
    .bin_o  (rbin)
  );
  assign occ      = wbin_d - rbin;
  assign wafull_d = occ >= PTR_WIDTH'(DEPTH - AFULL_MARGIN);
`else
  assign wafull_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      wovf_q   <= 1'b0;
      wafull_q <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wfull_q  <= wfull_d;
      wovf_q   <= wovf_q | (winc & wfull_q);
      wafull_q <= wafull_d;
    end
  end

  assign wptr   = wptr_q;
  assign waddr  = wbin_q[ADDR_WIDTH-1:0];
  assign wfull  = wfull_q;
  assign wovf   = wovf_q;
  assign wafull = wafull_q;
endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// tb_fifo_wr_ptr_full: directed stimulus against a counting model of the write side (writes accepted vs reads seen).
module tb_fifo_wr_ptr_full;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       winc = 1'b0;
  logic [3:0] wq2_rptr;
  logic [3:0] wptr;
  logic [2:0] waddr;
  logic       wen, wfull, wovf, wafull;
  int         rd = 0;
  int         tests = 0;
  int         fails = 0;

`ifdef FIFO_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  function automatic logic [3:0] g(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  assign wq2_rptr = g(rd);

  fifo_wr_ptr_full #(.AFULL_MARGIN(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .winc     (winc),
    .wq2_rptr (wq2_rptr),
    .wptr     (wptr),
    .waddr    (waddr),
    .wen      (wen),
    .wfull    (wfull),
    .wovf     (wovf),
    .wafull   (wafull)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Model: total accepted writes vs total reads; the flags follow from their difference.
  int m_w = 0;
  bit m_full = 0, m_ovf = 0, m_afull = 0;
  int acc, nw, occ;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_w <= 0; m_full <= 0; m_ovf <= 0; m_afull <= 0;
    end else begin
      acc = (winc && !m_full) ? 1 : 0;
      nw  = m_w + acc;
      occ = (nw - rd) & 15;
      m_w     <= nw;
      m_full  <= occ == 8;
      m_afull <= AF_EN && occ >= 6;
      m_ovf   <= m_ovf | (winc && m_full);
    end
  end

  logic [3:0] prev_wptr = '0;
  always @(negedge clk) begin
    if (!rst) prev_wptr = '0;
    else begin
      chk("wptr", wptr, g(m_w));
      chk("waddr", waddr, m_w & 7);
      chk("wen", wen, winc && !m_full);
      chk("wfull", wfull, m_full);
      chk("wovf", wovf, m_ovf);
      chk("wafull", wafull, m_afull);
      chk("gray_step", ($countones(wptr ^ prev_wptr) <= 1), 1);
      prev_wptr = wptr;
    end
  end

  task automatic edge_wait;
    @(posedge clk);
    #2;
  endtask

  logic [3:0] gseq [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

  initial begin
    #3;
    chk("rst_wptr", wptr, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_wovf", wovf, 0);
    #9 rst = 1'b1;
    edge_wait();
    for (int i = 0; i < 8; i++) begin
      winc = 1'b1;
      #1 chk("fill_waddr", waddr, i);
      edge_wait();
      chk("fill_wptr", wptr, gseq[i]);
    end
    chk("fill_full", wfull, 1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("ovf_wen", wen, 0);
      edge_wait();
      chk("ovf_wptr", wptr, 4'hC);
      chk("ovf_waddr", waddr, 0);
      chk("ovf_flag", wovf, 1);
    end
    winc = 1'b0;
    edge_wait();
    chk("ovf_sticky", wovf, 1);
    rd = 1;
    winc = 1'b1;
    edge_wait();
    chk("free_full", wfull, 0);
    chk("free_wptr_held", wptr, 4'hC);
    edge_wait();
    chk("refill_wptr", wptr, 4'hD);
    chk("refill_full", wfull, 1);
    for (int i = 0; i < 40; i++) begin
      winc = (i % 5) != 3;
      if ((i % 3) == 0 && rd < m_w) rd = rd + 1;
      edge_wait();
    end
    chk("wrap_seen", m_w > 16, 1);
    winc = 1'b1;
    edge_wait();
    rst = 1'b0;
    #1;
    chk("mid_rst_wptr", wptr, 0);
    chk("mid_rst_waddr", waddr, 0);
    chk("mid_rst_wfull", wfull, 0);
    chk("mid_rst_wovf", wovf, 0);
    winc = 1'b0;
    rd = 0;
    edge_wait();
    #1 rst = 1'b1;
    edge_wait();
`ifdef FIFO_ALMOST_FULL_EN
    winc = 1'b1;
    for (int i = 0; i < 5; i++) edge_wait();
    chk("afull_occ5", wafull, 0);
    edge_wait();
    chk("afull_occ6", wafull, 1);
    winc = 1'b0;
    rd = 1;
    edge_wait();
    chk("afull_drop", wafull, 0);
`endif
    edge_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
